// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: multi-cycle A - B - Bin, one 4-bit nibble per clock using borrow-select.
module nibble_serial_subtractor #(
  parameter int N_NIB = 4
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Run,
  input  logic [4*N_NIB-1:0] A,
  input  logic [4*N_NIB-1:0] B,
  input  logic               Bin,
  output logic [4*N_NIB-1:0] D,
  output logic               Bout,
  output logic               V,
  output logic               Busy,
  output logic               Done
);
  localparam int W  = 4*N_NIB;
  localparam int CW = $clog2(N_NIB)+1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [W-1:0] a_q, b_q, a_sh, b_sh, d_next;
  logic [CW-1:0] cnt;
  logic brw, last;
  logic [4:0] d0, d1, sel;
  // Both borrow candidates are formed every cycle; bit 4 of each is its nibble borrow-out.
  always_comb begin
    a_sh = a_q >> {cnt, 2'b00};
    b_sh = b_q >> {cnt, 2'b00};
    d0 = {1'b0, a_sh[3:0]} - {1'b0, b_sh[3:0]};
    d1 = d0 - 5'd1;
    sel = brw ? d1 : d0;
    last = cnt == CW'(N_NIB-1);
    d_next = D;
    for (int j = 0; j < N_NIB; j++)
      if (cnt == CW'(j)) d_next[4*j +: 4] = sel[3:0];
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      cnt <= '0;
      brw <= 1'b0;
      D <= '0;
      Bout <= 1'b0;
      V <= 1'b0;
      Busy <= 1'b0;
      Done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (Run) begin
          a_q <= A;
          b_q <= B;
          brw <= Bin;
          cnt <= '0;
          state <= CALC;
          Busy <= 1'b1;
        end
        CALC: begin
          D <= d_next;
          brw <= sel[4];
          cnt <= cnt + CW'(1);
          if (last) begin
            state <= DONE;
            Busy <= 1'b0;
            Done <= 1'b1;
            Bout <= sel[4];
            V <= (a_q[W-1] != b_q[W-1]) && (d_next[W-1] != a_q[W-1]);
          end
        end
        DONE: if (!Run) begin
          state <= IDLE;
          Done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb_nibble_serial_subtractor: directed and random operations against an integer-arithmetic reference.
module tb_nibble_serial_subtractor;
  logic Clk = 1'b0, Reset_n = 1'b0, Run = 1'b0, Bin = 1'b0;
  logic [15:0] A = '0, B = '0, D;
  logic Bout, V, Busy, Done;
  int n_cmp = 0, n_bad = 0;

  nibble_serial_subtractor #(.N_NIB(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .A(A), .B(B), .Bin(Bin),
    .D(D), .Bout(Bout), .V(V), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic bin,
                       output logic [15:0] d, output logic bo, output logic v);
    int ua, ub, sa, sb, r;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    d = 16'(ua - ub - int'(bin));
    bo = ua < ub + int'(bin);
    r = sa - sb - int'(bin);
    v = (r < -32768) || (r > 32767);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin, input bit scramble);
    logic [15:0] ed;
    logic eb, ev;
    int busy_n = 0;
    model(a, b, bin, ed, eb, ev);
    @(negedge Clk);
    A = a; B = b; Bin = bin; Run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      Run = 1'b0;
      if (scramble) begin A = 16'hFFFF; B = 16'hFFFF; Bin = ~bin; end
      if (Done) break;
      busy_n += int'(Busy);
    end
    check("done", Done, 1);
    check("busy_cycles", busy_n, 4);
    check("d", D, ed);
    check("bout", Bout, eb);
    check("v", V, ev);
    @(negedge Clk);
    check("idle_done", Done, 0);
    check("idle_hold_d", D, ed);
  endtask

  initial begin
    int busy_n;
    #2;
    check("rst_d", D, 0);
    check("rst_flags", {Bout, V, Busy, Done}, 0);
    @(negedge Clk); Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    check("no_run_idle", {Busy, Done}, 0);

    run_op(16'h1234, 16'h0034, 1'b0, 0);
    run_op(16'h0000, 16'h0001, 1'b0, 0);
    run_op(16'h8000, 16'h0001, 1'b0, 0);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 0);
    run_op(16'h0010, 16'h0000, 1'b1, 1);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 0);

    // Run held high: exactly one pass, Done held until Run drops.
    @(negedge Clk);
    A = 16'h00A0; B = 16'h0001; Bin = 1'b0; Run = 1'b1;
    busy_n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      busy_n += int'(Busy);
    end
    check("hold_busy", busy_n, 4);
    check("hold_done", Done, 1);
    check("hold_d", D, 16'h009F);
    Run = 1'b0;
    @(negedge Clk);
    check("hold_release", {Busy, Done}, 0);

    // Asynchronous reset between CALC edges abandons the operation.
    @(negedge Clk);
    A = 16'h1111; B = 16'h2222; Bin = 1'b0; Run = 1'b1;
    @(posedge Clk); @(negedge Clk); Run = 1'b0;
    @(posedge Clk); @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check("arst_d", D, 0);
    check("arst_flags", {Bout, V, Busy, Done}, 0);
    @(negedge Clk); Reset_n = 1'b1;
    busy_n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      busy_n += int'(Busy) + int'(Done);
    end
    check("arst_no_resume", busy_n, 0);
    run_op(16'h0005, 16'h0003, 1'b0, 0);

    for (int k = 0; k < 30; k++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
